// File: rtl/control_pkg.sv
// control_pkg: shared constants and the default microcode table for control_sequencer.
//   FETCH0/FETCH1 : the two fetch control words that start every instruction
//   END_BIT       : END bit position in the default 10-bit control word
//   HALT_OP       : opcode that stops the sequencer when built with HALT_EN
//   default_word  : control word for {opcode, flag, exec_step}; unlisted entries are NOP
package control_pkg;

  localparam int unsigned END_BIT = 9;
  localparam logic [9:0]  FETCH0  = 10'h0AA;
  localparam logic [9:0]  FETCH1  = 10'h092;
  localparam logic [3:0]  HALT_OP = 4'hF;

  // exec_step counts from 0 at the first step after the two fetch steps.
  function automatic logic [9:0] default_word(input logic [31:0] op, input logic flag,
                                              input logic [31:0] exec_step);
    logic [9:0] w;
    w = 10'h000;
    case (op)
      32'd0: if (exec_step == 32'd0) w = 10'h200;
      32'd1: begin
        if (exec_step == 32'd0) w = 10'h0AC;
        if (exec_step == 32'd1) w = 10'h0AE;
      end
      32'd5: begin
        if (flag) begin
          if (exec_step < 32'd2) w = 10'h0CF;
        end else begin
          if (exec_step == 32'd0) w = 10'h20F;
        end
      end
      default: w = 10'h000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: step-control bundle between the instruction register/flags side
// (master: en, opcode, flag) and the sequencer (slave: ctrl_word, step, instr_done, halted).
interface control_sequencer_if #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned CTRL_W   = 10,
  parameter int unsigned STEPS    = 4
) ();
  localparam int unsigned StepW = $clog2(STEPS);

  logic                en;
  logic [OPCODE_W-1:0] opcode;
  logic                flag;
  logic [CTRL_W-1:0]   ctrl_word;
  logic [StepW-1:0]    step;
  logic                instr_done;
  logic                halted;

  modport master (
    output en, opcode, flag,
    input  ctrl_word, step, instr_done, halted
  );

  modport slave (
    input  en, opcode, flag,
    output ctrl_word, step, instr_done, halted
  );
endinterface

// File: rtl/control_store.sv
// control_store: combinational microcode lookup filled from control_pkg::default_word.
//   op_i        : opcode seen by the current instruction
//   flag_i      : condition flag seen by the current instruction
//   exec_step_i : execute-phase step index (0 = first step after fetch)
//   word_o      : control word for that entry
module control_store
  import control_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned CTRL_W   = 10,
  parameter int unsigned STEPS    = 4,
  localparam int unsigned StepW   = $clog2(STEPS)
) (
  input  logic [OPCODE_W-1:0] op_i,
  input  logic                flag_i,
  input  logic [StepW-1:0]    exec_step_i,
  output logic [CTRL_W-1:0]   word_o
);

  always_comb begin
    word_o = CTRL_W'(default_word(32'(op_i), flag_i, 32'(exec_step_i)));
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: microcoded control unit. Each enabled step emits one registered control
// word: FETCH0, FETCH1, then table words until END or the last step.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of control_sequencer_if (en/opcode/flag in; ctrl_word, step,
//              instr_done, halted out)
// Build option: define HALT_EN to make the all-ones opcode stop the sequencer until reset;
// otherwise all-ones is an ordinary opcode and halted stays 0.
module control_sequencer
  import control_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned CTRL_W   = 10,
  parameter int unsigned STEPS    = 4
) (
  input  logic                clk,
  input  logic                rst,
  control_sequencer_if.slave  bus
);

  localparam int unsigned StepW = $clog2(STEPS);

  logic [StepW-1:0]    step_q, step_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                flag_q, flag_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                done_q, done_d;
  logic                halted_q, halted_d;

  logic [OPCODE_W-1:0] op_eff;
  logic                flag_eff;
  logic [StepW-1:0]    exec_step;
  logic [CTRL_W-1:0]   table_word, word, fetch0_w, fetch1_w;
  logic                in_fetch1, last_step, halt_hit;

  assign in_fetch1 = (step_q == StepW'(1));

  always_comb begin
    // Fetch words can never terminate an instruction.
    fetch0_w           = CTRL_W'(FETCH0);
    fetch0_w[CTRL_W-1] = 1'b0;
    fetch1_w           = CTRL_W'(FETCH1);
    fetch1_w[CTRL_W-1] = 1'b0;
    // At the second fetch step the live opcode/flag are used and latched in the same edge.
    op_eff    = in_fetch1 ? bus.opcode : op_q;
    flag_eff  = in_fetch1 ? bus.flag : flag_q;
    exec_step = step_q - StepW'(2);
  end

  control_store #(
    .OPCODE_W (OPCODE_W),
    .CTRL_W   (CTRL_W),
    .STEPS    (STEPS)
  ) u_store (
    .op_i        (op_eff),
    .flag_i      (flag_eff),
    .exec_step_i (exec_step),
    .word_o      (table_word)
  );

`ifdef HALT_EN
  assign halt_hit = in_fetch1 && (&bus.opcode);
`else
  assign halt_hit = 1'b0;
`endif

  always_comb begin
    if (step_q == StepW'(0)) begin
      word = fetch0_w;
    end else if (in_fetch1) begin
      word = fetch1_w;
    end else begin
      word = table_word;
    end
    last_step = (step_q == StepW'(STEPS - 1)) ||
                ((step_q >= StepW'(2)) && word[CTRL_W-1]);
  end

  always_comb begin
    step_d   = step_q;
    op_d     = op_q;
    flag_d   = flag_q;
    ctrl_d   = ctrl_q;
    done_d   = 1'b0;
    halted_d = halted_q;
    if (halted_q) begin
      ctrl_d = '0;
      step_d = '0;
    end else if (bus.en) begin
      ctrl_d = word;
      if (in_fetch1) begin
        op_d   = bus.opcode;
        flag_d = bus.flag;
      end
      if (halt_hit) begin
        halted_d = 1'b1;
        step_d   = '0;
      end else if (last_step) begin
        step_d = '0;
        done_d = 1'b1;
      end else begin
        step_d = step_q + StepW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= '0;
      op_q     <= '0;
      flag_q   <= 1'b0;
      ctrl_q   <= '0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      op_q     <= op_d;
      flag_q   <= flag_d;
      ctrl_q   <= ctrl_d;
      done_q   <= done_d;
      halted_q <= halted_d;
    end
  end

  assign bus.ctrl_word  = ctrl_q;
  assign bus.step       = step_q;
  assign bus.instr_done = done_q;
  assign bus.halted     = halted_q;

endmodule
